// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-memory loader:
//   - load-stream format constants (length field and word size in bytes)
//   - loader FSM state encoding
//   - per-state status/handshake decode used to build the registered outputs
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHK state).
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int LEN_BYTES  = 2;   // big-endian word count field
   localparam int WORD_BYTES = 4;   // bytes per instruction word, big-endian

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK    = 3'd5,
`endif
      DONE   = 3'd6,
      ERR    = 3'd7
   } state_t;

   // Status and handshake flags that depend only on the FSM state.
   typedef struct packed {
      logic byte_ready;
      logic busy;
      logic done;
      logic err;
      logic cpu_clrn;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = 5'b00000;

   // Flags to present while the FSM sits in state s.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = CTRL_IDLE;
      case (s)
         LEN_HI, LEN_LO, DATA: begin
            c.byte_ready = 1'b1;
            c.busy       = 1'b1;
         end
         WRITE: begin
            c.busy = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: begin
            c.byte_ready = 1'b1;
            c.busy       = 1'b1;
         end
`endif
         DONE: begin
            c.done     = 1'b1;
            c.cpu_clrn = 1'b1;
         end
         ERR: begin
            c.err = 1'b1;
         end
         default: begin
            c = CTRL_IDLE;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write bus.
//   byte_valid  source -> loader  source has a byte on byte_data
//   byte_data   source -> loader  load-stream byte
//   byte_ready  loader -> source  loader accepts a byte this cycle
//   we          loader -> memory  one-cycle write strobe per word
//   waddr       loader -> memory  word-aligned byte address
//   wdata       loader -> memory  instruction word
// Modports: master = loader side (drives the memory bus),
//           slave  = environment side (byte source + instruction memory).
// -----------------------------------------------------------------------------
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;

   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output we,
      output waddr,
      output wdata
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  we,
      input  waddr,
      input  wdata
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Shifts accepted bytes into a 32-bit word, most significant byte first.
//   clk           clock, rising edge
//   clrn          synchronous active-low reset
//   i_clear       restart assembly (new load), drops any partial word
//   i_byte_en     a byte is accepted this cycle
//   i_byte        the accepted byte
//   o_word        assembled word (valid while o_word_valid is high)
//   o_last_byte   the byte accepted this cycle completes a word
//   o_word_valid  one-cycle pulse, the cycle after a word completes
// -----------------------------------------------------------------------------
module word_assembler
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic        i_clear,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_last_byte,
   output logic        o_word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [31:0] r_shift;
   logic [1:0]  r_cnt;
   logic        r_word_valid;

   assign o_last_byte  = i_byte_en && (r_cnt == LAST_IDX);
   assign o_word       = r_shift;
   assign o_word_valid = r_word_valid;

   // Byte shift register, byte-in-word counter and word-complete pulse.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_shift      <= 32'h0000_0000;
         r_cnt        <= 2'd0;
         r_word_valid <= 1'b0;
      end else if (i_clear) begin
         r_shift      <= 32'h0000_0000;
         r_cnt        <= 2'd0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= o_last_byte;
         if (i_byte_en) begin
            r_shift <= {r_shift[23:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program from a byte stream into instruction memory while holding
// the cpu in reset. Stream: 2-byte big-endian word count N, then N big-endian
// 32-bit words (plus one trailing checksum byte when checksumming is built in).
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- adds the CHK state which
// consumes a trailing byte that must equal the mod-256 sum of all data bytes.
// Parameter ADDR_W : instruction-memory word-address width (2^ADDR_W words).
// Ports:
//   clk       clock, rising edge
//   clrn      synchronous active-low reset
//   start     one-cycle load request (ignored while busy)
//   bus       imem_loader_if.master: byte stream in, memory write bus out
//   cpu_clrn  active-low cpu reset, released only in DONE
//   busy      load in progress
//   done      load completed successfully
//   err       load rejected (length too large / checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 6
)
(
   input  logic          clk,
   input  logic          clrn,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_clrn,
   output logic          busy,
   output logic          done,
   output logic          err
);

   // Largest word count that fits the memory; 17 bits so ADDR_W = 16 works.
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t LOAD_END = CHK;
`else
   localparam state_t LOAD_END = DONE;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   ctrl_t       r_ctrl;
   logic [15:0] r_len;
   logic [15:0] r_wcnt;
   logic [31:0] r_waddr;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   logic        w_accept;
   logic        w_start_acc;
   logic        w_asm_en;
   logic        w_last_byte;
   logic        w_word_valid;
   logic [31:0] w_word;
   logic [15:0] w_len_full;

   assign w_accept    = bus.byte_valid && r_ctrl.byte_ready;
   assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
   assign w_asm_en    = w_accept && (r_state == DATA);
   // Word count as seen while its low byte is being accepted.
   assign w_len_full  = {r_len[15:8], bus.byte_data};

   word_assembler u_asm (
      .clk          (clk),
      .clrn         (clrn),
      .i_clear      (w_start_acc),
      .i_byte_en    (w_asm_en),
      .i_byte       (bus.byte_data),
      .o_word       (w_word),
      .o_last_byte  (w_last_byte),
      .o_word_valid (w_word_valid)
   );

   // Next-state logic of the load FSM.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE, ERR: begin
            if (start) begin
               w_state_nxt = LEN_HI;
            end else begin
               w_state_nxt = r_state;
            end
         end
         LEN_HI: begin
            if (w_accept) begin
               w_state_nxt = LEN_LO;
            end else begin
               w_state_nxt = LEN_HI;
            end
         end
         LEN_LO: begin
            if (!w_accept) begin
               w_state_nxt = LEN_LO;
            end else if (w_len_full == 16'd0) begin
               w_state_nxt = LOAD_END;
            end else if ({1'b0, w_len_full} > MAX_WORDS) begin
               w_state_nxt = ERR;
            end else begin
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            if (w_last_byte) begin
               w_state_nxt = WRITE;
            end else begin
               w_state_nxt = DATA;
            end
         end
         WRITE: begin
            if ((r_wcnt + 16'd1) == r_len) begin
               w_state_nxt = LOAD_END;
            end else begin
               w_state_nxt = DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: begin
            if (!w_accept) begin
               w_state_nxt = CHK;
            end else if (bus.byte_data == r_csum) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = ERR;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; status flags are registered from the next state so they
   // always match the state they describe.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_state <= IDLE;
         r_ctrl  <= CTRL_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_ctrl  <= state_ctrl(w_state_nxt);
      end
   end

   // Length capture, write address / word counter and running checksum.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_len   <= 16'd0;
         r_wcnt  <= 16'd0;
         r_waddr <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum  <= 8'd0;
`endif
      end else if (w_start_acc) begin
         r_len   <= 16'd0;
         r_wcnt  <= 16'd0;
         r_waddr <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum  <= 8'd0;
`endif
      end else begin
         if ((r_state == LEN_HI) && w_accept) begin
            r_len[15:8] <= bus.byte_data;
         end
         if ((r_state == LEN_LO) && w_accept) begin
            r_len[7:0] <= bus.byte_data;
         end
         // Address advances once the current word has been presented.
         if (r_state == WRITE) begin
            r_waddr <= r_waddr + 32'd4;
            r_wcnt  <= r_wcnt + 16'd1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (w_asm_en) begin
            r_csum <= r_csum + bus.byte_data;
         end
`endif
      end
   end

   assign bus.byte_ready = r_ctrl.byte_ready;
   // The assembler's word-complete pulse lines up exactly with the WRITE state.
   assign bus.we         = w_word_valid;
   assign bus.waddr      = r_waddr;
   assign bus.wdata      = w_word;
   assign busy           = r_ctrl.busy;
   assign done           = r_ctrl.done;
   assign err            = r_ctrl.err;
   assign cpu_clrn       = r_ctrl.cpu_clrn;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader. Each load pushes the expected memory
// writes and the expected final status into queues; a monitor pops and
// compares whenever the loader writes or finishes a load.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 6;
   localparam int MAX_N  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic clrn;
   logic start;
   logic cpu_clrn;
   logic busy;
   logic done;
   logic err;

   imem_loader_if bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .start    (start),
      .bus      (bus),
      .cpu_clrn (cpu_clrn),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [2:0]  exp_st[$];   // {done, err, cpu_clrn} at end of load
   logic [31:0] words[$];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, 64'({bus.we, bus.byte_ready, busy, done, err, cpu_clrn}), 64'h0);
      check({tag, "_waddr"}, 64'(bus.waddr), 64'h0);
      check({tag, "_wdata"}, 64'(bus.wdata), 64'h0);
   endtask

   // Watches the write bus and load completion on the falling edge.
   task automatic monitor();
      logic prev_busy;
      wr_t  w;
      logic [2:0] s;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (clrn !== 1'b1) begin
            prev_busy = 1'b0;
         end else begin
            if (bus.we === 1'b1) begin
               if (exp_wr.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_write: got we=1 addr 0x%0h data 0x%0h, required no write",
                           bus.waddr, bus.wdata);
               end else begin
                  w = exp_wr.pop_front();
                  check("write_addr", 64'(bus.waddr), 64'(w.addr));
                  check("write_data", 64'(bus.wdata), 64'(w.data));
               end
               check("write_ready_busy_cpuclrn", 64'({bus.byte_ready, busy, cpu_clrn}), 64'(3'b010));
            end
            if (prev_busy && (busy === 1'b0)) begin
               if (exp_st.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_load_end: got done=%b err=%b, required no load end", done, err);
               end else begin
                  s = exp_st.pop_front();
                  check("status_done_err_cpuclrn", 64'({done, err, cpu_clrn}), 64'(s));
               end
            end
            prev_busy = (busy === 1'b1);
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.byte_valid = 1'b0;
         bus.byte_data  = 8'($urandom);
         @(negedge clk);
      end
   endtask

   // Present one byte (after a random idle gap) until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int gap_lo, input int gap_hi);
      bit acc;
      acc = 1'b0;
      idle_cycles(int'($urandom_range(gap_hi, gap_lo)));
      for (int t = 0; t < 64 && !acc; t++) begin
         bus.byte_valid = 1'b1;
         bus.byte_data  = b;
         acc = (bus.byte_ready === 1'b1);
         @(negedge clk);
      end
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      check("byte_accepted", 64'(acc), 64'h1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy === 1'b1) && (t < 3000)) begin
         @(negedge clk);
         t++;
      end
      check("load_finished_in_time", 64'(busy), 64'h0);
      @(negedge clk);
   endtask

   // One complete load of words[0..n-1]; the model decides the expected
   // writes and final status from the stream rules alone.
   task automatic run_load(input int n, input bit bad_ck, input int gap_lo, input int gap_hi,
                           input bit poke);
      logic [15:0] n16;
      logic [7:0]  sum;
      bit          ok;
      wr_t         w;
      n16 = 16'(n);
      sum = 8'd0;
      ok  = (n <= MAX_N);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            w.addr = 32'(i * 4);
            w.data = words[i];
            exp_wr.push_back(w);
            sum = sum + words[i][31:24] + words[i][23:16] + words[i][15:8] + words[i][7:0];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (ok && bad_ck) ok = 1'b0;
`endif
      exp_st.push_back({ok, !ok, ok});

      pulse_start();
      send_byte(n16[15:8], gap_lo, gap_hi);
      send_byte(n16[7:0], gap_lo, gap_hi);
      if (n <= MAX_N) begin
         for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--) begin
               send_byte(words[i][8*b +: 8], gap_lo, gap_hi);
               if (poke && (b == 2)) pulse_start();
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(bad_ck ? (sum + 8'd1) : sum, gap_lo, gap_hi);
`else
         if (bad_ck) sum = sum + 8'd1;
`endif
      end
      wait_idle();
      check("pending_writes", 64'(exp_wr.size()), 64'h0);
      check("pending_status", 64'(exp_st.size()), 64'h0);
   endtask

   task automatic random_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      clrn           = 1'b0;
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      check_reset("por");
      clrn = 1'b1;
      @(negedge clk);
      check_reset("post_reset");

      // Two-word reference program.
      words = {32'h2008_0005, 32'h2009_000A};
      run_load(2, 1'b0, 0, 0, 1'b0);

      // Word count one beyond capacity is rejected without writes.
      words.delete();
      run_load(MAX_N + 1, 1'b0, 0, 1, 1'b0);

      // byte_valid toggled every other cycle.
      words = {32'hDEAD_BEEF};
      run_load(1, 1'b0, 1, 1, 1'b0);

      // Reset in the middle of a word, then a clean reload.
      pulse_start();
      send_byte(8'h00, 0, 0);
      send_byte(8'h01, 0, 0);
      send_byte(8'hA1, 0, 0);
      send_byte(8'hB2, 0, 0);
      clrn = 1'b0;
      @(negedge clk);
      check_reset("midword_reset");
      @(negedge clk);
      clrn = 1'b1;
      words = {32'h1234_5678};
      run_load(1, 1'b0, 0, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words = {32'h0102_0304};
      run_load(1, 1'b0, 0, 0, 1'b0);
      run_load(1, 1'b1, 0, 0, 1'b0);
`endif

      // start pulses while busy are ignored.
      random_words(3);
      run_load(3, 1'b0, 0, 2, 1'b1);

      // Empty program.
      words.delete();
      run_load(0, 1'b0, 0, 0, 1'b0);

      // Full memory: last write at 4*(2^ADDR_W - 1).
      random_words(MAX_N);
      run_load(MAX_N, 1'b0, 0, 0, 1'b0);

      // Randomised loads.
      for (int k = 0; k < 8; k++) begin
         int n;
         n = int'($urandom_range(6, 1));
         random_words(n);
         run_load(n, 1'($urandom_range(1, 0)), 0, 3, 1'($urandom_range(1, 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
